// File: rtl/dvs_power_ctrl.sv
// rtl/dvs_power_ctrl.sv - power-mode sequencer and statistics for the DVS moving-average filter
module dvs_power_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ACT_THRESH   = 256,
  parameter int IDLE_CYCLES  = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int WAKE_CYCLES  = 8,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     force_normal,
  input  logic                     clr_stats,
  output logic                     low_power_mode,
  output logic                     filt_valid,
  output logic [1:0]               state,
  output logic                     mode_change,
  output logic [CNT_W-1:0]         lp_cycles,
  output logic [CNT_W-1:0]         wake_count
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DRAIN  = 2'd1,
    LOW    = 2'd2,
    WAKE   = 2'd3
  } state_t;

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  localparam logic [IW-1:0]     IDLE_LAST  = IW'(IDLE_CYCLES - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0]     WAKE_LAST  = WW'(WAKE_CYCLES - 1);
  localparam logic [DATA_W:0]   THRESH     = (DATA_W + 1)'(ACT_THRESH);
  localparam logic [DATA_W:0]   MAG_ONE    = (DATA_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t            state_q;
  logic [IW-1:0]     idle_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [WW-1:0]     wake_cnt;
  logic [DATA_W:0]   ext;
  logic [DATA_W:0]   mag;
  logic              act;
  logic              wake_req;

  // Magnitude is one bit wider than the sample so the most negative value does not wrap
  always_comb begin
    ext      = {data_in[DATA_W-1], data_in};
    mag      = ext[DATA_W] ? (~ext + MAG_ONE) : ext;
    act      = sample_valid && (mag > THRESH);
    wake_req = act || force_normal;
  end

  assign state = state_q;

  // Mode sequencer: outputs are registered alongside the state they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= NORMAL;
      low_power_mode <= 1'b0;
      filt_valid     <= 1'b1;
      mode_change    <= 1'b0;
      idle_cnt       <= '0;
      drain_cnt      <= '0;
      wake_cnt       <= '0;
    end else begin
      mode_change <= 1'b0;
      case (state_q)
        NORMAL: begin
          if (wake_req) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_q   <= DRAIN;
            idle_cnt  <= '0;
            drain_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        DRAIN: begin
          if (wake_req) begin
            state_q  <= NORMAL;
            idle_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state_q        <= LOW;
            low_power_mode <= 1'b1;
            filt_valid     <= 1'b0;
            mode_change    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        LOW: begin
          if (wake_req) begin
            state_q        <= WAKE;
            low_power_mode <= 1'b0;
            mode_change    <= 1'b1;
            wake_cnt       <= '0;
          end
        end
        WAKE: begin
          // Refill time is fixed; new activity cannot stretch it
          if (wake_cnt == WAKE_LAST) begin
            state_q    <= NORMAL;
            filt_valid <= 1'b1;
            idle_cnt   <= '0;
          end else begin
            wake_cnt <= wake_cnt + WW'(1);
          end
        end
        default: begin
          state_q <= NORMAL;
        end
      endcase
    end
  end

  // Saturating statistics; a clear beats any increment in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp_cycles  <= '0;
      wake_count <= '0;
    end else begin
      if (clr_stats) begin
        lp_cycles <= '0;
      end else if (state_q == LOW && lp_cycles != '1) begin
        lp_cycles <= lp_cycles + CNT_ONE;
      end
      if (clr_stats) begin
        wake_count <= '0;
      end else if (state_q == LOW && wake_req && wake_count != '1) begin
        wake_count <= wake_count + CNT_ONE;
      end
    end
  end

endmodule
